// File: rtl/bcd_countdown_timer_pkg.sv
// Shared egg-timer constants: FSM state encoding, BCD digit limits and
// the default alarm duration used by every egg-timer block.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_ONES        = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS        = 4'd5;
  localparam int         DEFAULT_ALARM_TICKS = 30;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with programmable modulus (0..max_i), increment or
// decrement enable, synchronous clear, and combinational carry/borrow out.
module bcd_digit_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic [3:0] max_i,
  output logic [3:0] value_o,
  output logic       carry_o,
  output logic       borrow_o
);

  logic [3:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = 4'd0;
    end else if (inc_i) begin
      value_d = (value_q >= max_i) ? 4'd0 : value_q + 4'd1;
    end else if (dec_i) begin
      value_d = (value_q == 4'd0) ? max_i : value_q - 4'd1;
    end
  end

  // Carry/borrow ripple to the next digit within the same cycle.
  assign carry_o  = !clr_i && inc_i && (value_q >= max_i);
  assign borrow_o = !clr_i && !inc_i && dec_i && (value_q == 4'd0);
  assign value_o  = value_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS egg timer: SET / RUN / PAUSE / ALARM controller driving a chain of
// four BCD digit counters, with an alarm that self-clears after ALARM_TICKS.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int ALARM_TICKS = DEFAULT_ALARM_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       alarm
);

  localparam int                CNT_W     = $clog2(ALARM_TICKS + 1);
  localparam logic [CNT_W-1:0]  ACNT_LAST = CNT_W'(ALARM_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;
  logic             running_q, alarm_q;

  logic clr_time, inc_s, inc_m, dec_t;
  logic time_zero, time_one;

  logic c0, c1, c2, c3;
  logic b0, b1, b2, b3;
  logic unused_chain;

  assign time_zero = (digit0 == 4'd0) && (digit1 == 4'd0) &&
                     (digit2 == 4'd0) && (digit3 == 4'd0);
  assign time_one  = (digit0 == 4'd1) && (digit1 == 4'd0) &&
                     (digit2 == 4'd0) && (digit3 == 4'd0);

  always_comb begin
    state_d  = state_q;
    acnt_d   = '0;
    clr_time = 1'b0;
    inc_s    = 1'b0;
    inc_m    = 1'b0;
    dec_t    = 1'b0;
    if (clear) begin
      state_d  = ST_SET;
      clr_time = 1'b1;
    end else begin
      unique case (state_q)
        ST_SET: begin
          if (start_stop) begin
            if (!time_zero) state_d = ST_RUN;
          end else begin
            inc_s = inc_sec;
            inc_m = inc_min;
          end
        end
        ST_RUN: begin
          dec_t = tick;
          // A tick landing on 00:01 wins over a simultaneous pause request.
          if (tick && time_one)  state_d = ST_ALARM;
          else if (start_stop)   state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (start_stop) state_d = ST_RUN;
        end
        ST_ALARM: begin
          if (start_stop) begin
            state_d = ST_SET;
          end else if (tick) begin
            if (acnt_q == ACNT_LAST) state_d = ST_SET;
            else                     acnt_d  = acnt_q + 1'b1;
          end else begin
            acnt_d = acnt_q;
          end
        end
        default: state_d = ST_SET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SET;
      acnt_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acnt_q    <= acnt_d;
      running_q <= (state_d == ST_RUN);
      alarm_q   <= (state_d == ST_ALARM);
    end
  end

  assign running = running_q;
  assign alarm   = alarm_q;

  // Seconds tens never carries into minutes; minutes tens wraps 9 -> 0.
  bcd_digit_counter u_sec_ones (
    .clk(clk), .reset(reset), .clr_i(clr_time), .inc_i(inc_s), .dec_i(dec_t),
    .max_i(BCD_MAX_ONES), .value_o(digit0), .carry_o(c0), .borrow_o(b0)
  );

  bcd_digit_counter u_sec_tens (
    .clk(clk), .reset(reset), .clr_i(clr_time), .inc_i(c0), .dec_i(b0),
    .max_i(BCD_MAX_TENS), .value_o(digit1), .carry_o(c1), .borrow_o(b1)
  );

  bcd_digit_counter u_min_ones (
    .clk(clk), .reset(reset), .clr_i(clr_time), .inc_i(inc_m), .dec_i(b1),
    .max_i(BCD_MAX_ONES), .value_o(digit2), .carry_o(c2), .borrow_o(b2)
  );

  bcd_digit_counter u_min_tens (
    .clk(clk), .reset(reset), .clr_i(clr_time), .inc_i(c2), .dec_i(b2),
    .max_i(BCD_MAX_ONES), .value_o(digit3), .carry_o(c3), .borrow_o(b3)
  );

  assign unused_chain = c1 | c3 | b3;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed plus randomized bench for the egg timer against a seconds-based
// behavioural model.
module tb_bcd_countdown_timer;

  localparam int AT = 30;
  localparam int M_SET = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0, tick = 1'b0, start_stop = 1'b0, clear = 1'b0;
  logic       inc_min = 1'b0, inc_sec = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running, alarm;

  int n_checks = 0;
  int n_pass   = 0;

  int m_mm = 0, m_ss = 0, m_st = M_SET, m_acnt = 0;

  bcd_countdown_timer #(.ALARM_TICKS(AT)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
    .clear(clear), .inc_min(inc_min), .inc_sec(inc_sec),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] observed();
    return {digit3, digit2, digit1, digit0, running, alarm};
  endfunction

  function automatic logic [17:0] expected();
    logic [3:0] e3, e2, e1, e0;
    e3 = 4'(m_mm / 10);
    e2 = 4'(m_mm % 10);
    e1 = 4'(m_ss / 10);
    e0 = 4'(m_ss % 10);
    return {e3, e2, e1, e0, m_st == M_RUN, m_st == M_ALARM};
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: time held as whole minutes/seconds, decremented as a total.
  task automatic model_step(input logic r, t, ssb, c, im, is);
    int tot;
    if (r || c) begin
      m_mm = 0; m_ss = 0; m_st = M_SET; m_acnt = 0;
    end else begin
      case (m_st)
        M_SET: begin
          if (ssb) begin
            if (m_mm != 0 || m_ss != 0) m_st = M_RUN;
          end else begin
            if (is) m_ss = (m_ss + 1) % 60;
            if (im) m_mm = (m_mm + 1) % 100;
          end
        end
        M_RUN: begin
          if (t) begin
            tot  = m_mm * 60 + m_ss - 1;
            m_mm = tot / 60;
            m_ss = tot % 60;
          end
          if (t && m_mm == 0 && m_ss == 0) begin
            m_st = M_ALARM; m_acnt = 0;
          end else if (ssb) begin
            m_st = M_PAUSE;
          end
        end
        M_PAUSE: if (ssb) m_st = M_RUN;
        default: begin
          if (ssb) begin
            m_st = M_SET; m_acnt = 0;
          end else if (t) begin
            m_acnt++;
            if (m_acnt == AT) begin
              m_st = M_SET; m_acnt = 0;
            end
          end
        end
      endcase
    end
  endtask

  task automatic step(input logic r, t, ssb, c, im, is, input bit do_chk = 1'b1);
    reset = r; tick = t; start_stop = ssb; clear = c; inc_min = im; inc_sec = is;
    @(posedge clk);
    model_step(r, t, ssb, c, im, is);
    #1;
    reset = 0; tick = 0; start_stop = 0; clear = 0; inc_min = 0; inc_sec = 0;
    if (do_chk) chk("model", observed(), expected());
  endtask

  task automatic load(input int mm, input int ss);
    step(1, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < mm; i++) step(0, 0, 0, 0, 1, 0, 1'b0);
    for (int i = 0; i < ss; i++) step(0, 0, 0, 0, 0, 1, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0);
    chk("reset", observed(), 18'h0);

    // 3 min, 5 sec, start, 5 ticks -> 03:00 running
    load(3, 5);
    chk("load_0305", {digit3, digit2, digit1, digit0}, 16'h0305);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    chk("run_0300", observed(), {16'h0300, 2'b10});

    // Both increments in one SET cycle
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("both_inc", observed(), {16'h0101, 2'b00});

    // Borrow across minutes: 10:00 -> 09:59
    load(10, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("borrow_0959", observed(), {16'h0959, 2'b10});

    // 00:02 countdown to alarm, then auto-return after AT ticks
    load(0, 2);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("one_left", observed(), {16'h0001, 2'b10});
    step(0, 1, 0, 0, 0, 0);
    chk("alarm_on", observed(), {16'h0000, 2'b01});
    for (int i = 0; i < AT - 1; i++) step(0, 1, 0, 0, 0, 0);
    chk("alarm_hold", observed(), {16'h0000, 2'b01});
    step(0, 1, 0, 0, 0, 0);
    chk("alarm_done", observed(), {16'h0000, 2'b00});

    // start_stop aborts alarm immediately
    load(0, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("alarm_abort", observed(), {16'h0000, 2'b00});

    // Tick + pause together, pause holds, resume
    load(1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("tick_pause", observed(), {16'h0059, 2'b00});
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("pause_hold", observed(), {16'h0059, 2'b00});
    step(0, 0, 1, 0, 0, 0);
    chk("resume", observed(), {16'h0059, 2'b10});

    // Wrap limits in SET and start at zero ignored
    load(0, 59);
    step(0, 0, 0, 0, 0, 1);
    chk("sec_wrap", observed(), {16'h0000, 2'b00});
    load(99, 0);
    chk("load_9900", {digit3, digit2, digit1, digit0}, 16'h9900);
    step(0, 0, 0, 0, 1, 0);
    chk("min_wrap", observed(), {16'h0000, 2'b00});
    step(0, 0, 1, 0, 0, 0);
    chk("start_zero", observed(), {16'h0000, 2'b00});

    // Clear during RUN, then reset with everything asserted
    load(12, 34);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("clear_run", observed(), {16'h0000, 2'b00});
    load(12, 34);
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1);
    chk("reset_all", observed(), {16'h0000, 2'b00});

    // Random pulse stress
    for (int i = 0; i < 20000; i++) begin
      step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      chk("invariant",
          {17'h0, (digit0 <= 4'd9) && (digit1 <= 4'd5) && (digit2 <= 4'd9) &&
                  (digit3 <= 4'd9) && !(running && alarm)},
          18'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
